// File: rtl/updown_cmd_arbiter.sv
// Merges button and UART commands into counter controls (en/clear/mode) and
// queues one acknowledgement byte per pending command class to the UART TX.
//
// state    | meaning
// TX_IDLE  | waiting for a pending ack and an idle transmitter
// TX_START | tx_start pulse, tx_data holds the selected ack byte
// TX_WAIT  | waiting for tx_done or the timeout
module updown_cmd_arbiter #(
  parameter bit ECHO_EN    = 1'b1,
  parameter int TX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       en,
  output logic       clear,
  output logic       mode,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       tx_err
);

  localparam int CW = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  tx_state_t     state, state_next;
  logic          btn_run_d, btn_clear_d, btn_mode_d;
  logic          is_r, is_c, is_m;
  logic          run_evt, clear_evt, mode_evt, unk_evt;
  logic          flag_c, flag_rs, flag_ud, flag_q, any_flag;
  logic          clr_c, clr_rs, clr_ud, clr_q;
  logic          load, timeout;
  logic [7:0]    sel_byte;
  logic [CW-1:0] cnt;

  assign is_r = (rx_data == 8'h72) || (rx_data == 8'h52);
  assign is_c = (rx_data == 8'h63) || (rx_data == 8'h43);
  assign is_m = (rx_data == 8'h6D) || (rx_data == 8'h4D);

  // Button and UART sources of the same command OR together: one toggle per cycle.
  assign run_evt   = (btn_run & ~btn_run_d) | (rx_done & is_r);
  assign clear_evt = (btn_clear & ~btn_clear_d) | (rx_done & is_c);
  assign mode_evt  = (btn_mode & ~btn_mode_d) | (rx_done & is_m);
  assign unk_evt   = rx_done & ~(is_r | is_c | is_m);

  assign any_flag = flag_c | flag_rs | flag_ud | flag_q;
  assign tx_start = (state == TX_START);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_run_d   <= 1'b0;
      btn_clear_d <= 1'b0;
      btn_mode_d  <= 1'b0;
      en          <= 1'b0;
      mode        <= 1'b0;
      clear       <= 1'b0;
    end else begin
      btn_run_d   <= btn_run;
      btn_clear_d <= btn_clear;
      btn_mode_d  <= btn_mode;
      en          <= en ^ run_evt;
      mode        <= mode ^ mode_evt;
      clear       <= clear_evt;
    end
  end

  // A new event in the same cycle its flag is being serviced keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c  <= 1'b0;
      flag_rs <= 1'b0;
      flag_ud <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      flag_c  <= (flag_c & ~clr_c) | clear_evt;
      flag_rs <= (flag_rs & ~clr_rs) | run_evt;
      flag_ud <= (flag_ud & ~clr_ud) | mode_evt;
      flag_q  <= (flag_q & ~clr_q) | unk_evt;
    end
  end

  always_comb begin
    sel_byte = 8'h3F;
    if (flag_c)       sel_byte = 8'h43;
    else if (flag_rs) sel_byte = en ? 8'h52 : 8'h53;
    else if (flag_ud) sel_byte = mode ? 8'h44 : 8'h55;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    timeout    = 1'b0;
    clr_c      = 1'b0;
    clr_rs     = 1'b0;
    clr_ud     = 1'b0;
    clr_q      = 1'b0;
    case (state)
      TX_IDLE: begin
        if (ECHO_EN && any_flag && !tx_busy) begin
          load       = 1'b1;
          state_next = TX_START;
          if (flag_c)       clr_c  = 1'b1;
          else if (flag_rs) clr_rs = 1'b1;
          else if (flag_ud) clr_ud = 1'b1;
          else              clr_q  = 1'b1;
        end
      end
      TX_START: state_next = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          state_next = TX_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= 8'h00;
      cnt     <= '0;
      tx_err  <= 1'b0;
    end else begin
      if (load) tx_data <= sel_byte;
      if (state == TX_START)     cnt <= '0;
      else if (state == TX_WAIT) cnt <= cnt + CW'(1);
      if (timeout) tx_err <= 1'b1;
    end
  end

endmodule
